int_sched: RTL and testbench

- Prioritised interrupt controller/scheduler that sequences interrupt entry into the microcoded control unit.
- Captures IRQ edges, arbitrates by fixed priority and raises `interrupt` to the control unit.
- Issues a one-cycle `CallInt` with a vector address, then holds off further entries until the control unit pulses `ret`.
- Sits between peripherals/bus and the control unit; configured through a small register window on the data bus.

---
 rtl/int_sched_pkg.sv | 41 ++++
 rtl/int_sched_if.sv | 28 ++
 rtl/int_sync_edge.sv | 30 +++
 rtl/int_sched.sv | 174 +++++++++++++++++
 tb/tb_int_sched.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/int_sched_pkg.sv
// int_sched_pkg: shared types and constants for the interrupt scheduler.
//   state_e     - scheduler FSM states
//   ADDR_*      - register window addresses on cfg_addr
//   GIE_BIT     - global interrupt enable position in the IE register
//   find_first  - lowest-index set bit (index 0 = highest priority)
package int_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_CALL = 2'd2,
        ST_SVC  = 2'd3
    } state_e;

    localparam logic [1:0] ADDR_IE     = 2'd0;
    localparam logic [1:0] ADDR_PEND   = 2'd1;
    localparam logic [1:0] ADDR_INSVC  = 2'd2;
    localparam logic [1:0] ADDR_SWTRIG = 2'd3;

    localparam int GIE_BIT = 15;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    function automatic pick_t find_first(input logic [7:0] v);
        pick_t p;
        p.found = 1'b0;
        p.idx   = 3'd0;
        // Scan from the top so the last hit is the lowest index.
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                p.found = 1'b1;
                p.idx   = 3'(i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/int_sched_if.sv
// int_sched_if: configuration bus and control-unit handshake of int_sched.
//   cfg_we/cfg_addr/cfg_wdata -> register writes, cfg_rdata <- combinational read
//   ret                       -> return-from-interrupt pulse
//   interrupt/CallInt/int_vector/int_id <- entry sequencing to the control unit
// master: bus/control-unit side, slave: int_sched.
interface int_sched_if #(
    parameter int ADDR_W = 16
);
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [15:0]       cfg_wdata;
    logic [15:0]       cfg_rdata;
    logic              ret;
    logic              interrupt;
    logic              CallInt;
    logic [ADDR_W-1:0] int_vector;
    logic [2:0]        int_id;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, ret,
        input  cfg_rdata, interrupt, CallInt, int_vector, int_id
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, ret,
        output cfg_rdata, interrupt, CallInt, int_vector, int_id
    );
endinterface

// File: rtl/int_sync_edge.sv
// int_sync_edge: 2-flop synchroniser plus rising-edge detector, W lines wide.
//   CLK, RSTn - clock, async active-low reset
//   async_i   - asynchronous input lines
//   rise_o    - one-cycle pulse per synchronised rising edge
module int_sync_edge #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] rise_o
);
    logic [W-1:0] sync1_q;
    logic [W-1:0] sync2_q;
    logic [W-1:0] prev_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;
endmodule

// File: rtl/int_sched.sv
// int_sched: prioritised interrupt scheduler in front of the microcoded control unit.
//   CLK, RSTn - clock, async active-low reset
//   irq       - asynchronous rising-edge interrupt lines, index 0 highest priority
//   bus       - int_sched_if.slave: register window and control-unit handshake
// Optional build macro INT_SCHED_NESTING_EN: strictly higher-priority requests
// preempt the one in service; INSVC then holds a stack of active entries.
//
// state | meaning
// IDLE  | waiting for an eligible request with nothing in service
// ARB   | winner latched in int_id, re-checked once before committing
// CALL  | one-cycle CallInt with int_vector, PEND->INSVC transfer
// SVC   | handler running, waiting for ret
module int_sched
    import int_sched_pkg::*;
#(
    parameter int                NIRQ       = 4,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 16'h0010,
    parameter logic [ADDR_W-1:0] VEC_STRIDE = 16'h0004
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic [NIRQ-1:0] irq,
    int_sched_if.slave      bus
);
    state_e          state_q, state_d;
    logic [2:0]      int_id_q, int_id_d;
    logic [NIRQ-1:0] ie_q, ie_d;
    logic            gie_q, gie_d;
    logic [NIRQ-1:0] pend_q, pend_d;
    logic [NIRQ-1:0] insvc_q, insvc_d;

    logic [NIRQ-1:0] irq_rise;
    logic [NIRQ-1:0] id_mask;
    logic [NIRQ-1:0] elig_q, elig_d;
    logic [NIRQ-1:0] wmask;
    logic            wr_ie, wr_pend, wr_swtrig;
    logic            commit, ret_take;
    pick_t           win;
    logic            unused_wdata;

    int_sync_edge #(.W(NIRQ)) u_sync (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .async_i (irq),
        .rise_o  (irq_rise)
    );

    assign wmask        = bus.cfg_wdata[NIRQ-1:0];
    assign wr_ie        = bus.cfg_we && (bus.cfg_addr == ADDR_IE);
    assign wr_pend      = bus.cfg_we && (bus.cfg_addr == ADDR_PEND);
    assign wr_swtrig    = bus.cfg_we && (bus.cfg_addr == ADDR_SWTRIG);
    assign unused_wdata = ^bus.cfg_wdata;

    assign id_mask  = NIRQ'(1) << int_id_q;
    assign commit   = (state_q == ST_CALL);
    assign ret_take = (state_q == ST_SVC) && bus.ret;

    always_comb begin
        ie_d    = ie_q;
        gie_d   = gie_q;
        pend_d  = pend_q;
        insvc_d = insvc_q;
        if (wr_ie) begin
            ie_d  = wmask;
            gie_d = bus.cfg_wdata[GIE_BIT];
        end
        if (wr_pend) pend_d = pend_d & ~wmask;
        if (commit)  pend_d = pend_d & ~id_mask;
        // Sets are applied last so a hardware edge beats a same-cycle clear.
        pend_d = pend_d | irq_rise;
        if (wr_swtrig) pend_d = pend_d | wmask;
        if (commit)    insvc_d = insvc_d | id_mask;
        if (ret_take)  insvc_d = insvc_d & ~id_mask;
    end

    assign elig_q = pend_q & ie_q & {NIRQ{gie_q}};
    // ARB re-checks against next-cycle register values so that a write landing
    // during ARB itself still cancels the entry.
    assign elig_d = pend_d & ie_d & {NIRQ{gie_d}};
    assign win    = find_first(8'(elig_q));

`ifdef INT_SCHED_NESTING_EN
    pick_t top;
    pick_t nxt;
    assign top = find_first(8'(insvc_q));
    assign nxt = find_first(8'(insvc_q & ~id_mask));
`endif

    always_comb begin
        state_d  = state_q;
        int_id_d = int_id_q;
        case (state_q)
            ST_IDLE: begin
                if (win.found && (insvc_q == '0)) begin
                    int_id_d = win.idx;
                    state_d  = ST_ARB;
                end
            end
            ST_ARB: begin
                if ((elig_d & id_mask) != '0) begin
                    state_d = ST_CALL;
                end else begin
`ifdef INT_SCHED_NESTING_EN
                    if (top.found) begin
                        int_id_d = top.idx;
                        state_d  = ST_SVC;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_CALL: state_d = ST_SVC;
            ST_SVC: begin
                if (bus.ret) begin
`ifdef INT_SCHED_NESTING_EN
                    if (nxt.found) int_id_d = nxt.idx;
                    else           state_d  = ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
`ifdef INT_SCHED_NESTING_EN
                else if (win.found && (!top.found || (win.idx < top.idx))) begin
                    int_id_d = win.idx;
                    state_d  = ST_ARB;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= ST_IDLE;
            int_id_q <= '0;
            ie_q     <= '0;
            gie_q    <= 1'b0;
            pend_q   <= '0;
            insvc_q  <= '0;
        end else begin
            state_q  <= state_d;
            int_id_q <= int_id_d;
            ie_q     <= ie_d;
            gie_q    <= gie_d;
            pend_q   <= pend_d;
            insvc_q  <= insvc_d;
        end
    end

    always_comb begin
        bus.cfg_rdata = '0;
        case (bus.cfg_addr)
            ADDR_IE: begin
                bus.cfg_rdata          = 16'(ie_q);
                bus.cfg_rdata[GIE_BIT] = gie_q;
            end
            ADDR_PEND:  bus.cfg_rdata = 16'(pend_q);
            ADDR_INSVC: bus.cfg_rdata = 16'(insvc_q);
            default:    bus.cfg_rdata = '0;
        endcase
    end

    assign bus.interrupt  = (state_q == ST_ARB) || (state_q == ST_CALL);
    assign bus.CallInt    = (state_q == ST_CALL);
    assign bus.int_vector = (state_q == ST_CALL)
                          ? VEC_BASE + ADDR_W'(int_id_q) * VEC_STRIDE
                          : '0;
    assign bus.int_id     = int_id_q;
endmodule

// File: tb/tb_int_sched.sv
module tb_int_sched;
    import int_sched_pkg::*;

    logic       CLK  = 1'b0;
    logic       RSTn = 1'b0;
    logic [3:0] irq  = 4'h0;
    int         cyc  = 0;
    int         total = 0;
    int         bad   = 0;

    int_sched_if #(.ADDR_W(16)) bus ();

    int_sched #(
        .NIRQ       (4),
        .ADDR_W     (16),
        .VEC_BASE   (16'h0010),
        .VEC_STRIDE (16'h0004)
    ) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .irq  (irq),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] vec;
        logic [2:0]  id;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];

    // Record every CallInt with the cycle it appeared in.
    always @(posedge CLK) begin
        #1;
        if (RSTn && bus.CallInt === 1'b1)
            obs_q.push_back('{bus.int_vector, bus.int_id, cyc});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000ns");
        $fatal(1);
    end

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        @(negedge CLK);
        bus.cfg_we    = 1'b0;
        bus.cfg_wdata = 16'h0;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [15:0] d);
        bus.cfg_addr = a;
        #1;
        d = bus.cfg_rdata;
    endtask

    task automatic ret_pulse();
        bus.ret = 1'b1;
        @(negedge CLK);
        bus.ret = 1'b0;
    endtask

    task automatic wait_obs(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (obs_q.size() > 0) begin
                got = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        logic [15:0] d;
        RSTn = 1'b0;
        irq  = 4'hF;
        repeat (3) @(negedge CLK);
        total++;
        if ({bus.interrupt, bus.CallInt, bus.int_vector, bus.int_id} !== 21'h0) begin
            bad++;
            $display("FAIL reset_outputs: got int=%b call=%b vec=%h id=%0d, required all 0",
                     bus.interrupt, bus.CallInt, bus.int_vector, bus.int_id);
        end
        cfg_read(ADDR_PEND, d);
        total++;
        if (d !== 16'h0) begin
            bad++;
            $display("FAIL reset_pend: got %h, required 0000", d);
        end
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (5) @(negedge CLK);
        cfg_read(ADDR_PEND, d);
        total++;
        if (d !== 16'h000F) begin
            bad++;
            $display("FAIL post_reset_pend: got %h, required 000f", d);
        end
        total++;
        if (bus.interrupt !== 1'b0 || obs_q.size() != 0) begin
            bad++;
            $display("FAIL post_reset_no_int: got int=%b calls=%0d, required 0 and 0",
                     bus.interrupt, obs_q.size());
        end
        irq = 4'h0;
        cfg_write(ADDR_PEND, 16'h000F);
        cfg_read(ADDR_PEND, d);
        total++;
        if (d !== 16'h0) begin
            bad++;
            $display("FAIL pend_w1c: got %h, required 0000", d);
        end
    endtask

    task automatic test_single();
        logic [15:0] d;
        bit          got;
        ev_t         e, o;
        cfg_write(ADDR_IE, 16'h8004);
        irq = 4'b0100;
        exp_q.push_back('{16'h0018, 3'd2, cyc + 5});
        repeat (3) @(negedge CLK);
        irq = 4'b0000;
        wait_obs(got);
        e = exp_q.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL single_call: no CallInt seen, required vec=%h id=%0d", e.vec, e.id);
        end else begin
            o = obs_q.pop_front();
            if (o.vec !== e.vec || o.id !== e.id || o.cyc != e.cyc) begin
                bad++;
                $display("FAIL single_call: got vec=%h id=%0d cyc=%0d, required vec=%h id=%0d cyc=%0d",
                         o.vec, o.id, o.cyc, e.vec, e.id, e.cyc);
            end
        end
        @(negedge CLK);
        cfg_read(ADDR_INSVC, d);
        total++;
        if (d !== 16'h0004 || bus.int_id !== 3'd2 || bus.interrupt !== 1'b0) begin
            bad++;
            $display("FAIL single_svc: got insvc=%h id=%0d int=%b, required 0004 2 0",
                     d, bus.int_id, bus.interrupt);
        end
        ret_pulse();
        cfg_read(ADDR_INSVC, d);
        total++;
        if (d !== 16'h0) begin
            bad++;
            $display("FAIL single_ret: got insvc=%h, required 0000", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d, d2;
        bit          got;
        ev_t         e, o;
        cfg_write(ADDR_IE, 16'h800A);
        exp_q.push_back('{16'h0014, 3'd1, cyc + 3});
        cfg_write(ADDR_SWTRIG, 16'h000A);
        wait_obs(got);
        e = exp_q.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL b2b_first: no CallInt seen, required vec=%h id=%0d", e.vec, e.id);
        end else begin
            o = obs_q.pop_front();
            if (o.vec !== e.vec || o.id !== e.id || o.cyc != e.cyc) begin
                bad++;
                $display("FAIL b2b_first: got vec=%h id=%0d cyc=%0d, required vec=%h id=%0d cyc=%0d",
                         o.vec, o.id, o.cyc, e.vec, e.id, e.cyc);
            end
        end
        @(negedge CLK);
        cfg_read(ADDR_PEND, d);
        cfg_read(ADDR_INSVC, d2);
        total++;
        if (d !== 16'h0008 || d2 !== 16'h0002) begin
            bad++;
            $display("FAIL b2b_regs: got pend=%h insvc=%h, required 0008 0002", d, d2);
        end
        exp_q.push_back('{16'h001C, 3'd3, cyc + 3});
        ret_pulse();
        wait_obs(got);
        e = exp_q.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL b2b_second: no CallInt seen, required vec=%h id=%0d", e.vec, e.id);
        end else begin
            o = obs_q.pop_front();
            if (o.vec !== e.vec || o.id !== e.id || o.cyc != e.cyc) begin
                bad++;
                $display("FAIL b2b_second: got vec=%h id=%0d cyc=%0d, required vec=%h id=%0d cyc=%0d",
                         o.vec, o.id, o.cyc, e.vec, e.id, e.cyc);
            end
        end
        @(negedge CLK);
        ret_pulse();
        cfg_read(ADDR_PEND, d);
        cfg_read(ADDR_INSVC, d2);
        total++;
        if (d !== 16'h0 || d2 !== 16'h0) begin
            bad++;
            $display("FAIL b2b_done: got pend=%h insvc=%h, required 0000 0000", d, d2);
        end
    endtask

    task automatic test_abort();
        logic [15:0] d;
        cfg_write(ADDR_IE, 16'h8001);
        cfg_write(ADDR_SWTRIG, 16'h0001);
        @(negedge CLK);
        total++;
        if (bus.interrupt !== 1'b1 || bus.CallInt !== 1'b0) begin
            bad++;
            $display("FAIL abort_in_arb: got int=%b call=%b, required 1 0", bus.interrupt, bus.CallInt);
        end
        cfg_write(ADDR_IE, 16'h0001);
        total++;
        if (bus.interrupt !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: got int=%b, required 0", bus.interrupt);
        end
        repeat (6) @(negedge CLK);
        cfg_read(ADDR_PEND, d);
        total++;
        if (obs_q.size() != 0 || d !== 16'h0001) begin
            bad++;
            $display("FAIL abort_result: got calls=%0d pend=%h, required 0 0001", obs_q.size(), d);
        end
    endtask

    task automatic test_w1c_race();
        logic [15:0] d;
        irq = 4'b0001;
        repeat (2) @(negedge CLK);
        cfg_write(ADDR_PEND, 16'h0001);
        cfg_read(ADDR_PEND, d);
        total++;
        if (d !== 16'h0001) begin
            bad++;
            $display("FAIL w1c_race: got pend=%h, required 0001", d);
        end
        irq = 4'b0000;
        cfg_write(ADDR_PEND, 16'h0001);
        cfg_read(ADDR_PEND, d);
        total++;
        if (d !== 16'h0) begin
            bad++;
            $display("FAIL w1c_plain: got pend=%h, required 0000", d);
        end
    endtask

    task automatic test_nesting();
        logic [15:0] d;
        bit          got;
        ev_t         e, o;
        cfg_write(ADDR_IE, 16'h8005);
        irq = 4'b0100;
        exp_q.push_back('{16'h0018, 3'd2, cyc + 5});
        repeat (3) @(negedge CLK);
        irq = 4'b0000;
        wait_obs(got);
        e = exp_q.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL nest_first: no CallInt seen, required vec=%h id=%0d", e.vec, e.id);
        end else begin
            o = obs_q.pop_front();
            if (o.vec !== e.vec || o.id !== e.id || o.cyc != e.cyc) begin
                bad++;
                $display("FAIL nest_first: got vec=%h id=%0d cyc=%0d, required vec=%h id=%0d cyc=%0d",
                         o.vec, o.id, o.cyc, e.vec, e.id, e.cyc);
            end
        end
        repeat (2) @(negedge CLK);
        irq = 4'b0001;
`ifdef INT_SCHED_NESTING_EN
        exp_q.push_back('{16'h0010, 3'd0, cyc + 5});
        repeat (3) @(negedge CLK);
        irq = 4'b0000;
        wait_obs(got);
        e = exp_q.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL nest_preempt: no CallInt seen, required vec=%h id=%0d", e.vec, e.id);
        end else begin
            o = obs_q.pop_front();
            if (o.vec !== e.vec || o.id !== e.id || o.cyc != e.cyc) begin
                bad++;
                $display("FAIL nest_preempt: got vec=%h id=%0d cyc=%0d, required vec=%h id=%0d cyc=%0d",
                         o.vec, o.id, o.cyc, e.vec, e.id, e.cyc);
            end
        end
        @(negedge CLK);
        cfg_read(ADDR_INSVC, d);
        total++;
        if (d !== 16'h0005) begin
            bad++;
            $display("FAIL nest_insvc: got %h, required 0005", d);
        end
        ret_pulse();
        repeat (3) @(negedge CLK);
        cfg_read(ADDR_INSVC, d);
        total++;
        if (d !== 16'h0004 || bus.int_id !== 3'd2 || bus.interrupt !== 1'b0 || obs_q.size() != 0) begin
            bad++;
            $display("FAIL nest_first_ret: got insvc=%h id=%0d int=%b calls=%0d, required 0004 2 0 0",
                     d, bus.int_id, bus.interrupt, obs_q.size());
        end
`else
        repeat (3) @(negedge CLK);
        irq = 4'b0000;
        repeat (6) @(negedge CLK);
        cfg_read(ADDR_PEND, d);
        total++;
        if (obs_q.size() != 0 || d !== 16'h0001) begin
            bad++;
            $display("FAIL no_preempt: got calls=%0d pend=%h, required 0 0001", obs_q.size(), d);
        end
        exp_q.push_back('{16'h0010, 3'd0, cyc + 3});
        ret_pulse();
        wait_obs(got);
        e = exp_q.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL after_ret_call: no CallInt seen, required vec=%h id=%0d", e.vec, e.id);
        end else begin
            o = obs_q.pop_front();
            if (o.vec !== e.vec || o.id !== e.id || o.cyc != e.cyc) begin
                bad++;
                $display("FAIL after_ret_call: got vec=%h id=%0d cyc=%0d, required vec=%h id=%0d cyc=%0d",
                         o.vec, o.id, o.cyc, e.vec, e.id, e.cyc);
            end
        end
        @(negedge CLK);
`endif
        ret_pulse();
        cfg_read(ADDR_INSVC, d);
        total++;
        if (d !== 16'h0) begin
            bad++;
            $display("FAIL nest_done: got insvc=%h, required 0000", d);
        end
    endtask

    initial begin
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = 2'd0;
        bus.cfg_wdata = 16'h0;
        bus.ret       = 1'b0;
        @(negedge CLK);
        test_reset();
        test_single();
        test_back_to_back();
        test_abort();
        test_w1c_race();
        test_nesting();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
